ucsbece154_mem_arbiter: RTL
===========================

# ucsbece154_mem_arbiter

Two-requester arbiter that shares the single burst-read instruction/text memory port between the instruction-fetch side (I) and the data/prefetch side (D). It wins one requester per transaction, presents its address to the memory, and holds that address stable for the whole burst. It forwards exactly `BURST_BEATS` data beats back to the winner, then releases the port. A watchdog aborts a transaction whose memory stops responding.

## Interface
- `BURST_BEATS`, 8: beats per memory transaction (demand block plus prefetch block).
- `MAX_WAIT`, 64: maximum cycles allowed between issue and a beat, or between consecutive beats, before abort. Must exceed the memory first-word delay.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `i_req` in 1: I-side read request, level.
- `i_addr` in 32: I-side read address.
- `i_grant` out 1: I-side owns the port.
- `i_data` out 32: beat data to the I side.
- `i_ready` out 1: beat valid to the I side.
- `i_err` out 1: one-cycle abort pulse to the I side.
- `d_req`, `d_addr`, `d_grant`, `d_data`, `d_ready`, `d_err`: D-side equivalents, same widths and meanings.
- `mem_req` out 1: read request to the memory.
- `mem_addr` out 32: read address to the memory.
- `mem_data` in 32: memory beat data.
- `mem_ready` in 1: memory beat valid.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, STREAM, ABORT. Encoding is registered; all state changes occur on `clk`.
- **IDLE**
  - Requests are sampled only here.
  - Exactly one request: that side wins.
  - Both requests: the side that did not win last wins (round-robin). `last_winner` resets to D, so I wins the first tie.
  - Winner's address is latched into `addr_q`, `grant_q` is set, and `last_winner` is updated. Next state is ISSUE.
- **ISSUE**
  - `mem_req`=1 for exactly this one cycle.
  - Wait counter and beat counter are cleared. Next state is WAIT.
- **WAIT**
  - Wait counter increments each cycle.
  - On `mem_ready`: forward the beat, beat counter goes to 1, next state is STREAM. If `BURST_BEATS`==1, next state is IDLE instead.
  - If the wait counter reaches `MAX_WAIT`-1 with no beat, next state is ABORT.
- **STREAM**
  - On `mem_ready`: forward the beat, increment the beat counter, clear the wait counter.
  - When the forwarded beat is number `BURST_BEATS`, next state is IDLE.
  - Otherwise the wait counter increments each cycle without a beat. Reaching `MAX_WAIT`-1 sends the state to ABORT.
- **ABORT**
  - Winner's `x_err`=1 for one cycle.
  - Grant is cleared. Next state is IDLE.
- **Address hold:** `mem_addr` = `addr_q` from ISSUE through the final beat. The memory re-samples its address while fetching, so `addr_q` must not change until return to IDLE. In IDLE, `mem_addr` holds its last value (0 after reset).
- **Forwarding** is combinational:
  - `x_ready` = `mem_ready` & `x_grant` & (state is WAIT or STREAM).
  - `x_data` = `mem_data` when `x_grant`, otherwise 0.
- `x_grant` is high from ISSUE through the last beat or ABORT, for one side only. It is never high for both.
- **Widths:** beat counter is `$clog2(BURST_BEATS)+1` bits; wait counter is `$clog2(MAX_WAIT)` bits. Neither wraps during a valid transaction.
- **Requester rules:**
  - Hold `x_req` and `x_addr` stable until `x_grant` rises.
  - Deassert `x_req` after the last beat, or the request is treated as a new one.
  - Address changes while not granted are ignored.
- **Ignored `mem_ready`:** beats seen in IDLE, ISSUE or ABORT are not forwarded. This covers stale beats after reset or abort.

## Timing
- Reset values: state IDLE; `i_grant`, `d_grant`, `i_ready`, `d_ready`, `i_err`, `d_err`, `mem_req`, `busy` all 0; `mem_addr` 0; `i_data`, `d_data` 0.
- Request seen in IDLE at cycle N: grant and `busy` high at N+1; `mem_req` high only at N+1.
- Beat-to-requester latency is 0 cycles (same-cycle pass-through).
- After the last beat at cycle M: state IDLE at M+1, grant low at M+1. A pending request is arbitrated at M+1 and granted at M+2. Minimum gap between transactions is 2 cycles.
- Reset asserted mid-transaction: IDLE on the next edge, grants and `x_ready` drop immediately after that edge, and no `x_err` is pulsed.
- Abort: `x_err` is high the cycle after the counter reaches `MAX_WAIT`-1; IDLE the cycle after that.

## Test plan
- **Single I request.** `i_req`=1 with `i_addr`=0x00010008; memory first beat 40 cycles after `mem_req`, then 8 consecutive beats.
  - `mem_req` pulses once.
  - `mem_addr` stays 0x00010008 throughout.
  - `i_ready` high for exactly 8 cycles, `d_ready` never.
  - `i_grant` drops the cycle after the 8th beat.
- **Simultaneous requests after reset.** `i_req` and `d_req` both 1.
  - I is granted first, D second, with 2 idle cycles between transactions.
  - With both held continuously, grants alternate I, D, I.
- **D request during an I burst.** `d_req` rises mid-burst.
  - No effect on `mem_addr` or the I beats.
  - D is granted 2 cycles after the I burst ends.
- **Timeout.** Memory never asserts `mem_ready` after `mem_req`.
  - `i_err` pulses at cycle 64 after ISSUE.
  - Then `busy`=0 and the arbiter accepts a new request.
- **Mid-stream stall.** 3 beats arrive, then `mem_ready` stays low 20 cycles, then the remaining 5 beats.
  - All 8 beats are forwarded and no error is raised.
  - A stall of 64 cycles instead aborts with `i_err`.
- **Reset mid-burst** after beat 4.
  - Grants drop and state returns to IDLE.
  - Further `mem_ready` pulses produce no `i_ready` and no `d_ready`.

Source files
------------

// File: rtl/ucsbece154_mem_arbiter.sv
// Two-requester burst-read arbiter for the shared instruction/text memory port.
// Round-robin on ties, address held for the whole burst, watchdog abort on a silent memory.
module ucsbece154_mem_arbiter #(
   parameter int BURST_BEATS = 8,
   parameter int MAX_WAIT    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_grant,
   output logic [31:0] i_data,
   output logic        i_ready,
   output logic        i_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   output logic        d_grant,
   output logic [31:0] d_data,
   output logic        d_ready,
   output logic        d_err,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        mem_ready,
   output logic        busy
);

   localparam int BEAT_W = $clog2(BURST_BEATS) + 1;
   localparam int WAIT_W = $clog2(MAX_WAIT);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_BEATS);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 2);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STREAM, ABORT} state_t;

   state_t              state;
   logic [31:0]         addr_q;
   logic                i_grant_q, d_grant_q;
   logic                last_winner_d;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                mem_req_q, i_err_q, d_err_q;
   logic                pick_i, pick_d, timeout, in_burst;

   // On a tie the side that did not win last time goes first.
   assign pick_i   = i_req && (!d_req || last_winner_d);
   assign pick_d   = d_req && !pick_i;
   // The counter reaches MAX_WAIT-1 on this edge, so the abort pulse lands one cycle later.
   assign timeout  = (wait_cnt == WAIT_LIMIT);
   assign in_burst = (state == WAIT) || (state == STREAM);

   // NOTE: every state register uses <= so all next-state decisions read the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         addr_q        <= '0;
         i_grant_q     <= 1'b0;
         d_grant_q     <= 1'b0;
         last_winner_d <= 1'b1;
         beat_cnt      <= '0;
         wait_cnt      <= '0;
         mem_req_q     <= 1'b0;
         i_err_q       <= 1'b0;
         d_err_q       <= 1'b0;
      end else begin
         mem_req_q <= 1'b0;
         i_err_q   <= 1'b0;
         d_err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_i || pick_d) begin
                  addr_q        <= pick_i ? i_addr : d_addr;
                  i_grant_q     <= pick_i;
                  d_grant_q     <= pick_d;
                  last_winner_d <= pick_d;
                  mem_req_q     <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               beat_cnt <= '0;
               state    <= WAIT;
            end
            WAIT, STREAM: begin
               if (mem_ready) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  wait_cnt <= '0;
                  if (beat_cnt + BEAT_W'(1) == LAST_BEAT) begin
                     i_grant_q <= 1'b0;
                     d_grant_q <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     state <= STREAM;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
                  if (timeout) begin
                     i_err_q <= i_grant_q;
                     d_err_q <= d_grant_q;
                     state   <= ABORT;
                  end
               end
            end
            ABORT: begin
               i_grant_q <= 1'b0;
               d_grant_q <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign i_grant  = i_grant_q;
   assign d_grant  = d_grant_q;
   assign i_ready  = mem_ready && i_grant_q && in_burst;
   assign d_ready  = mem_ready && d_grant_q && in_burst;
   assign i_data   = i_grant_q ? mem_data : '0;
   assign d_data   = d_grant_q ? mem_data : '0;
   assign i_err    = i_err_q;
   assign d_err    = d_err_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = addr_q;
   assign busy     = (state != IDLE);

endmodule
